// File: rtl/vga_state_seq_pkg.sv
// Shared VGA definitions: H/V timing constants, H/V state and colour-state encodings,
// plus the button debouncer state encoding used by vga_state_seq.
package vga_state_seq_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_PULSE   = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_PULSE   = 2;
  localparam int unsigned V_BACK    = 33;

  typedef enum logic [1:0] {H_VIS = 2'd0, H_FP = 2'd1, H_SYNC = 2'd2, H_BP = 2'd3} h_state_e;
  typedef enum logic [1:0] {V_VIS = 2'd0, V_FP = 2'd1, V_SYNC = 2'd2, V_BP = 2'd3} v_state_e;

  typedef enum logic [1:0] {
    COL_RED   = 2'd0,
    COL_GREEN = 2'd1,
    COL_BLUE  = 2'd2,
    COL_WHITE = 2'd3
  } col_e;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'd0,
    DB_ARM_HI  = 2'd1,
    DB_PRESSED = 2'd2,
    DB_ARM_LO  = 2'd3
  } db_state_e;

  // Colour sequence order; wraps white back to red.
  function automatic logic [1:0] next_col(input logic [1:0] col);
    return col + 2'd1;
  endfunction

endpackage

// File: rtl/vga_state_seq_btn_debounce.sv
// Button debouncer: a level must hold for DEBOUNCE_CYCLES cycles in an ARM state to be accepted;
// a registered press_pulse fires once per accepted press.
module btn_debounce
  import vga_state_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_sync,
  output logic press_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_e        state;
  db_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             press_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= DB_IDLE;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      press_pulse <= press_nxt;
    end
  end

  // A bounce in an ARM state falls back to the originating state with the count cleared.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    press_nxt = 1'b0;
    case (state)
      DB_IDLE: begin
        if (btn_sync) state_nxt = DB_ARM_HI;
      end
      DB_ARM_HI: begin
        if (!btn_sync) begin
          state_nxt = DB_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DB_PRESSED;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DB_PRESSED: begin
        if (!btn_sync) state_nxt = DB_ARM_LO;
      end
      DB_ARM_LO: begin
        if (btn_sync) begin
          state_nxt = DB_PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DB_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = DB_IDLE;
    endcase
  end

endmodule

// File: rtl/vga_state_seq.sv
// Frame-synchronous colour-state sequencer; vga_state only moves on a vsync falling edge.
// Optional manual-advance button is built only when VGA_SEQ_BTN_EN is defined.
module vga_state_seq
  import vga_state_seq_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 60,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       pause,
  input  logic       btn_next,
  output logic [1:0] vga_state,
  output logic       frame_tick,
  output logic       step_tick
);

  localparam int unsigned FCNT_W = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_STEP - 1);

  logic              vsync_q;
  logic [FCNT_W-1:0] fcnt;
  logic              fb;
  logic              auto_step;
  logic              pending;
  logic              do_step;

  assign fb        = vsync_q && !vsync;
  assign auto_step = fb && !pause && (fcnt == FCNT_LAST);
  assign do_step   = auto_step || pending;

`ifdef VGA_SEQ_BTN_EN
  logic btn_meta;
  logic btn_sync;
  logic press_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn_next;
      btn_sync <= btn_meta;
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk        (clk),
    .rst        (rst),
    .btn_sync   (btn_sync),
    .press_pulse(press_pulse)
  );

  // Single-bit request: extra presses within one frame collapse into one step.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (fb) begin
      pending <= press_pulse;
    end else if (press_pulse) begin
      pending <= 1'b1;
    end
  end
`else
  logic unused_btn_next;
  assign unused_btn_next = btn_next;
  assign pending         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q    <= 1'b1;
      fcnt       <= '0;
      vga_state  <= COL_RED;
      frame_tick <= 1'b0;
      step_tick  <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= fb;
      step_tick  <= fb && do_step;
      if (fb && !pause) begin
        fcnt <= auto_step ? '0 : fcnt + FCNT_W'(1);
      end
      if (fb && do_step) begin
        vga_state <= next_col(vga_state);
      end
    end
  end

endmodule

// File: tb/tb_vga_state_seq.sv
// Self-checking bench for vga_state_seq: random frame lengths and pause patterns checked
// against a frame-level model of the colour sequence.
module tb_vga_state_seq;

  localparam int unsigned FPS = 3;
  localparam int unsigned DBC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync;
  logic       pause;
  logic       btn_next;
  logic [1:0] vga_state;
  logic       frame_tick;
  logic       step_tick;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: unpaused frames since reset, current colour, outstanding button request.
  int m_frames;
  int m_state;
  bit m_pend;

  vga_state_seq #(
    .FRAMES_PER_STEP(FPS),
    .DEBOUNCE_CYCLES(DBC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vsync     (vsync),
    .pause     (pause),
    .btn_next  (btn_next),
    .vga_state (vga_state),
    .frame_tick(frame_tick),
    .step_tick (step_tick)
  );

  always #5 clk = ~clk;

  // Drives one frame (vsync high hi_len cycles, low 2) with optional button/reset events,
  // samples the outputs on every falling clock edge and advances the model by one frame.
  task automatic do_frame(input int hi_len, input int press_at, input bit toggle, input int rst_at,
                          output int ft, output int st, output int stray, output bit exp_step);
    logic [1:0] prev;
    bit auto;
    ft = 0; st = 0; stray = 0; auto = 0;
    prev = vga_state;
    for (int i = 0; i < hi_len + 3; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) ft++;
      if (step_tick === 1'b1) st++;
      if (vga_state !== prev && frame_tick !== 1'b1 && !rst) stray++;
      prev  = vga_state;
      vsync = (i >= hi_len && i < hi_len + 2) ? 1'b0 : 1'b1;
      rst   = (i == rst_at);
      if (toggle) btn_next = (i < 40) ? 1'(((i >> 1) & 1)) : 1'b0;
      else btn_next = (press_at >= 0 && i >= press_at && i < press_at + 6);
    end
`ifdef VGA_SEQ_BTN_EN
    if (press_at >= 0) m_pend = 1;
`endif
    if (rst_at >= 0) begin
      m_frames = 0; m_state = 0; m_pend = 0;
    end
    if (!pause) begin
      m_frames++;
      auto = (m_frames % FPS) == 0;
    end
    exp_step = auto || m_pend;
    m_pend   = 0;
    if (exp_step) m_state = (m_state + 1) % 4;
  endtask

  task automatic test_reset();
    rst = 1'b1; vsync = 1'b1; pause = 1'b0; btn_next = 1'b0;
    repeat (3) @(negedge clk);
    tests_run += 3;
    if (vga_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d expected 0", vga_state); end
    if (frame_tick !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_tick got %b expected 0", frame_tick); end
    if (step_tick !== 1'b0) begin tests_failed++; $display("FAIL reset_step_tick got %b expected 0", step_tick); end
    rst = 1'b0;
    m_frames = 0; m_state = 0; m_pend = 0;
  endtask

  task automatic test_auto_step();
    int ft, st, stray, steps;
    bit es;
    steps = 0;
    for (int f = 0; f < 12; f++) begin
      do_frame(17, -1, 0, -1, ft, st, stray, es);
      steps += st;
      tests_run += 4;
      if (ft !== 1) begin tests_failed++; $display("FAIL auto_frame_tick f%0d got %0d expected 1", f, ft); end
      if (st !== int'(es)) begin tests_failed++; $display("FAIL auto_step_tick f%0d got %0d expected %0d", f, st, es); end
      if (vga_state !== 2'(m_state)) begin tests_failed++; $display("FAIL auto_state f%0d got %0d expected %0d", f, vga_state, m_state); end
      if (stray !== 0) begin tests_failed++; $display("FAIL auto_stray f%0d got %0d expected 0", f, stray); end
    end
    tests_run++;
    if (steps !== 4) begin tests_failed++; $display("FAIL auto_total_steps got %0d expected 4", steps); end
    if (vga_state !== 2'd0) begin tests_run++; tests_failed++; $display("FAIL auto_wrap got %0d expected 0", vga_state); end
    else tests_run++;
  endtask

  task automatic test_pause();
    int ft, st, stray;
    bit es;
    do_frame(17, -1, 0, -1, ft, st, stray, es);
    pause = 1'b1;
    for (int f = 0; f < 6; f++) begin
      do_frame(17, -1, 0, -1, ft, st, stray, es);
      tests_run += 3;
      if (ft !== 1) begin tests_failed++; $display("FAIL pause_frame_tick f%0d got %0d expected 1", f, ft); end
      if (st !== 0) begin tests_failed++; $display("FAIL pause_step_tick f%0d got %0d expected 0", f, st); end
      if (vga_state !== 2'(m_state)) begin tests_failed++; $display("FAIL pause_state f%0d got %0d expected %0d", f, vga_state, m_state); end
    end
    pause = 1'b0;
    // Held count must resume where it stopped.
    for (int f = 0; f < 3; f++) begin
      do_frame(17, -1, 0, -1, ft, st, stray, es);
      tests_run += 2;
      if (st !== int'(es)) begin tests_failed++; $display("FAIL resume_step_tick f%0d got %0d expected %0d", f, st, es); end
      if (vga_state !== 2'(m_state)) begin tests_failed++; $display("FAIL resume_state f%0d got %0d expected %0d", f, vga_state, m_state); end
    end
  endtask

  task automatic test_random();
    int ft, st, stray;
    bit es;
    for (int f = 0; f < 16; f++) begin
      pause = 1'($urandom_range(0, 1));
      do_frame(int'($urandom_range(12, 24)), -1, 0, -1, ft, st, stray, es);
      tests_run += 3;
      if (ft !== 1) begin tests_failed++; $display("FAIL rand_frame_tick f%0d got %0d expected 1", f, ft); end
      if (st !== int'(es)) begin tests_failed++; $display("FAIL rand_step_tick f%0d got %0d expected %0d", f, st, es); end
      if (vga_state !== 2'(m_state) || stray !== 0) begin
        tests_failed++;
        $display("FAIL rand_state f%0d got %0d (stray %0d) expected %0d", f, vga_state, stray, m_state);
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_btn_press();
    int ft, st, stray;
    bit es;
    do_frame(18, 3, 0, -1, ft, st, stray, es);
    tests_run += 2;
    if (st !== int'(es)) begin tests_failed++; $display("FAIL btn_press_step got %0d expected %0d", st, es); end
    if (vga_state !== 2'(m_state)) begin tests_failed++; $display("FAIL btn_press_state got %0d expected %0d", vga_state, m_state); end
  endtask

  task automatic test_btn_bounce();
    int ft, st, stray;
    bit es;
    do_frame(45, -1, 1, -1, ft, st, stray, es);
    tests_run += 2;
    if (st !== int'(es)) begin tests_failed++; $display("FAIL bounce_step got %0d expected %0d", st, es); end
    if (vga_state !== 2'(m_state)) begin tests_failed++; $display("FAIL bounce_state got %0d expected %0d", vga_state, m_state); end
  endtask

  task automatic test_btn_coincide();
    int ft, st, stray, guard;
    bit es;
    guard = 0;
    while ((m_frames % FPS) != FPS - 1 && guard < 4) begin
      do_frame(17, -1, 0, -1, ft, st, stray, es);
      guard++;
    end
    do_frame(18, 3, 0, -1, ft, st, stray, es);
    tests_run += 2;
    if (st !== 1) begin tests_failed++; $display("FAIL coincide_step got %0d expected 1", st); end
    if (vga_state !== 2'(m_state)) begin tests_failed++; $display("FAIL coincide_state got %0d expected %0d", vga_state, m_state); end
    do_frame(17, -1, 0, -1, ft, st, stray, es);
    tests_run++;
    if (st !== int'(es)) begin tests_failed++; $display("FAIL coincide_after_step got %0d expected %0d", st, es); end
  endtask

  task automatic test_reset_mid();
    int ft, st, stray, guard;
    bit es;
    guard = 0;
    while ((m_frames % FPS) != FPS - 1 && guard < 4) begin
      do_frame(17, -1, 0, -1, ft, st, stray, es);
      guard++;
    end
    do_frame(18, 2, 0, 14, ft, st, stray, es);
    tests_run += 3;
    if (st !== 0) begin tests_failed++; $display("FAIL rstmid_step got %0d expected 0", st); end
    if (vga_state !== 2'd0) begin tests_failed++; $display("FAIL rstmid_state got %0d expected 0", vga_state); end
    if (ft !== 1) begin tests_failed++; $display("FAIL rstmid_frame_tick got %0d expected 1", ft); end
    for (int f = 0; f < 3; f++) begin
      do_frame(17, -1, 0, -1, ft, st, stray, es);
      tests_run++;
      if (st !== int'(es) || vga_state !== 2'(m_state)) begin
        tests_failed++;
        $display("FAIL rstmid_after f%0d step %0d state %0d expected step %0d state %0d", f, st, vga_state, es, m_state);
      end
    end
  endtask

  initial begin
    test_reset();
    test_auto_step();
    test_pause();
    test_random();
    test_btn_press();
    test_btn_bounce();
    test_btn_coincide();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
